// File: rtl/writeback_stage_if.sv
// MEM->WB bundle: MEM-stage inputs and pipeline controls in, register-file write port and status out.
interface writeback_stage_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 mem_valid;
  logic                 mem_regWrite;
  logic [4:0]           mem_writeReg;
  logic [1:0]           mem_memToReg;
  logic [31:0]          mem_aluResult;
  logic [31:0]          mem_readData;
  logic [31:0]          mem_pcPlus4;
  logic [1:0]           mem_loadSize;
  logic                 mem_loadUnsigned;
  logic                 stall;
  logic                 flush;
  logic                 regWrite;
  logic [4:0]           writeReg;
  logic [31:0]          writeData;
  logic                 wb_valid;
  logic                 load_fault;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    output mem_valid, mem_regWrite, mem_writeReg, mem_memToReg, mem_aluResult,
           mem_readData, mem_pcPlus4, mem_loadSize, mem_loadUnsigned, stall, flush,
    input  regWrite, writeReg, writeData, wb_valid, load_fault, retired
  );

  modport slave (
    input  mem_valid, mem_regWrite, mem_writeReg, mem_memToReg, mem_aluResult,
           mem_readData, mem_pcPlus4, mem_loadSize, mem_loadUnsigned, stall, flush,
    output regWrite, writeReg, writeData, wb_valid, load_fault, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with sub-word load extraction, misaligned-load detection
// and a retired-instruction counter; outputs stay stable for the register file's negedge write.
module writeback_stage #(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  writeback_stage_if.slave wb
);

  logic [1:0]           w_addr;
  logic [1:0]           w_lane;
  logic [15:0]          w_half;
  logic [7:0]           w_byte;
  logic                 w_is_load;
  logic                 w_misaligned;
  logic [31:0]          w_data;
  logic                 w_regWrite;
  logic                 w_fault;

  logic                 r_wb_valid;
  logic                 r_regWrite;
  logic [4:0]           r_writeReg;
  logic [31:0]          r_writeData;
  logic                 r_load_fault;
  logic [CNT_WIDTH-1:0] r_retired;

  // Misalignment only has meaning for loads; ALU and link results never fault.
  always_comb begin
    w_addr       = wb.mem_aluResult[1:0];
    w_is_load    = (wb.mem_memToReg == 2'b01);
    w_lane       = BIG_ENDIAN ? (2'd3 - w_addr) : w_addr;
    w_half       = (w_addr[1] ^ BIG_ENDIAN) ? wb.mem_readData[31:16] : wb.mem_readData[15:0];
    case (w_lane)
      2'd0:    w_byte = wb.mem_readData[7:0];
      2'd1:    w_byte = wb.mem_readData[15:8];
      2'd2:    w_byte = wb.mem_readData[23:16];
      default: w_byte = wb.mem_readData[31:24];
    endcase

    w_misaligned = 1'b0;
    w_data       = 32'h0;
    case (wb.mem_memToReg)
      2'b00: w_data = wb.mem_aluResult;
      2'b10: w_data = wb.mem_pcPlus4;
      2'b11: w_data = 32'h0;
      default: begin
        case (wb.mem_loadSize)
          2'b00: begin
            w_data       = wb.mem_readData;
            w_misaligned = |w_addr;
          end
          2'b01: begin
            w_data       = wb.mem_loadUnsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            w_misaligned = w_addr[0];
          end
          2'b10: begin
            w_data = wb.mem_loadUnsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
          end
          default: begin
            w_data       = 32'h0;
            w_misaligned = 1'b1;
          end
        endcase
      end
    endcase

    w_regWrite = wb.mem_valid & wb.mem_regWrite & (|wb.mem_writeReg) & ~w_misaligned
                 & (wb.mem_memToReg != 2'b11);
    w_fault    = wb.mem_valid & w_is_load & w_misaligned;
  end

  // The instruction leaving WB retires even if this edge also flushes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid   <= 1'b0;
      r_regWrite   <= 1'b0;
      r_writeReg   <= 5'd0;
      r_writeData  <= 32'h0;
      r_load_fault <= 1'b0;
      r_retired    <= '0;
    end else begin
      if (r_wb_valid && !wb.stall)
        r_retired <= r_retired + CNT_WIDTH'(1);
      if (wb.flush) begin
        r_wb_valid   <= 1'b0;
        r_regWrite   <= 1'b0;
        r_load_fault <= 1'b0;
      end else if (!wb.stall) begin
        r_wb_valid   <= wb.mem_valid;
        r_regWrite   <= w_regWrite;
        r_writeReg   <= wb.mem_writeReg;
        r_writeData  <= w_data;
        r_load_fault <= w_fault;
      end
    end
  end

  assign wb.wb_valid   = r_wb_valid;
  assign wb.regWrite   = r_regWrite;
  assign wb.writeReg   = r_writeReg;
  assign wb.writeData  = r_writeData;
  assign wb.load_fault = r_load_fault;
  assign wb.retired    = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench: big-endian/32-bit and little-endian/4-bit instances share stimulus;
// a byte-addressed reference model predicts each edge and monitors compare at the negedge.
module tb_writeback_stage;

  typedef struct {
    bit          v, rw;
    bit [4:0]    wr;
    bit [1:0]    m2r;
    bit [31:0]   alu, rd, pc;
    bit [1:0]    ls;
    bit          lu, st, fl;
  } stim_t;

  typedef struct {
    bit          v, rw, flt;
    bit [4:0]    wr;
    bit [31:0]   wd;
    int unsigned ret;
  } st_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  st_t  sa, sb;
  st_t  qa[$];
  st_t  qb[$];

  always #5 clock = ~clock;

  writeback_stage_if #(.CNT_WIDTH(32)) ifa ();
  writeback_stage_if #(.CNT_WIDTH(4))  ifb ();

  writeback_stage #(.BIG_ENDIAN(1'b1), .CNT_WIDTH(32)) dut_a (
    .clock(clock), .reset_n(reset_n), .wb(ifa.slave));
  writeback_stage #(.BIG_ENDIAN(1'b0), .CNT_WIDTH(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .wb(ifb.slave));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Memory view: byte at address a of a big-endian word is the (3-a)th byte from the bottom.
  function automatic st_t step(input st_t s, input stim_t x, input bit be);
    st_t         n;
    int unsigned a, raw;
    bit [31:0]   val;
    bit          mis;
    n = s;
    if (s.v && !x.st) n.ret = s.ret + 1;
    if (x.fl) begin
      n.v = 0; n.rw = 0; n.flt = 0;
      return n;
    end
    if (x.st) return n;
    a = x.alu % 4;
    mis = 0;
    val = 0;
    if (x.m2r == 0) val = x.alu;
    else if (x.m2r == 2) val = x.pc;
    else if (x.m2r == 1) begin
      if (x.ls == 0) begin
        val = x.rd; mis = (a != 0);
      end else if (x.ls == 1) begin
        mis = (a % 2 != 0);
        raw = be ? (x.rd >> (16 * (1 - a / 2))) % 65536 : (x.rd >> (16 * (a / 2))) % 65536;
        val = (x.lu || raw < 32768) ? raw : raw + 32'hFFFF_0000;
      end else if (x.ls == 2) begin
        raw = be ? (x.rd >> (8 * (3 - a))) % 256 : (x.rd >> (8 * a)) % 256;
        val = (x.lu || raw < 128) ? raw : raw + 32'hFFFF_FF00;
      end else mis = 1;
    end
    n.v   = x.v;
    n.wr  = x.wr;
    n.wd  = val;
    n.flt = x.v && x.m2r == 1 && mis;
    n.rw  = x.v && x.rw && x.wr != 0 && !mis && x.m2r != 3;
    return n;
  endfunction

  function automatic stim_t mk(bit v, bit rw, bit [4:0] wr, bit [1:0] m2r, bit [31:0] alu,
                               bit [31:0] rd, bit [31:0] pc, bit [1:0] ls, bit lu, bit st, bit fl);
    stim_t x;
    x.v = v; x.rw = rw; x.wr = wr; x.m2r = m2r; x.alu = alu; x.rd = rd; x.pc = pc;
    x.ls = ls; x.lu = lu; x.st = st; x.fl = fl;
    return x;
  endfunction

  task automatic drive(input stim_t x);
    ifa.mem_valid = x.v;  ifa.mem_regWrite = x.rw; ifa.mem_writeReg = x.wr;
    ifa.mem_memToReg = x.m2r; ifa.mem_aluResult = x.alu; ifa.mem_readData = x.rd;
    ifa.mem_pcPlus4 = x.pc; ifa.mem_loadSize = x.ls; ifa.mem_loadUnsigned = x.lu;
    ifa.stall = x.st; ifa.flush = x.fl;
    ifb.mem_valid = x.v;  ifb.mem_regWrite = x.rw; ifb.mem_writeReg = x.wr;
    ifb.mem_memToReg = x.m2r; ifb.mem_aluResult = x.alu; ifb.mem_readData = x.rd;
    ifb.mem_pcPlus4 = x.pc; ifb.mem_loadSize = x.ls; ifb.mem_loadUnsigned = x.lu;
    ifb.stall = x.st; ifb.flush = x.fl;
  endtask

  task automatic apply(input stim_t x);
    drive(x);
    @(posedge clock);
    sa = step(sa, x, 1'b1);
    sb = step(sb, x, 1'b0);
    qa.push_back(sa);
    qb.push_back(sb);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst.valid", ifa.wb_valid, 0);
    chk("rst.regWrite", ifa.regWrite, 0);
    chk("rst.writeReg", ifa.writeReg, 0);
    chk("rst.writeData", ifa.writeData, 0);
    chk("rst.fault", ifa.load_fault, 0);
    chk("rst.retiredA", ifa.retired, 0);
    chk("rst.retiredB", ifb.retired, 0);
    qa.delete();
    qb.delete();
    sa = '{default: 0};
    sb = '{default: 0};
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  always @(negedge clock) begin
    if (qa.size() > 0) begin
      st_t e;
      e = qa.pop_front();
      chk("A.wb_valid", ifa.wb_valid, e.v);
      chk("A.regWrite", ifa.regWrite, e.rw);
      chk("A.load_fault", ifa.load_fault, e.flt);
      chk("A.retired", ifa.retired, e.ret);
      if (e.v) begin
        chk("A.writeReg", ifa.writeReg, e.wr);
        chk("A.writeData", ifa.writeData, e.wd);
      end
    end
  end

  always @(negedge clock) begin
    if (qb.size() > 0) begin
      st_t e;
      e = qb.pop_front();
      chk("B.wb_valid", ifb.wb_valid, e.v);
      chk("B.regWrite", ifb.regWrite, e.rw);
      chk("B.load_fault", ifb.load_fault, e.flt);
      chk("B.retired", ifb.retired, e.ret % 16);
      if (e.v) begin
        chk("B.writeReg", ifb.writeReg, e.wr);
        chk("B.writeData", ifb.writeData, e.wd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    apply(mk(1, 1, 5, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0));
    chk("alu.regWrite", ifa.regWrite, 1);
    chk("alu.writeReg", ifa.writeReg, 5);
    chk("alu.writeData", ifa.writeData, 32'h0000_1234);
    chk("alu.valid", ifa.wb_valid, 1);
    apply(idle);
    chk("alu.retired", ifa.retired, 1);

    apply(mk(1, 1, 8, 1, 32'h100, 32'h80FF_7F01, 0, 2, 0, 0, 0));
    chk("lb.a0", ifa.writeData, 32'hFFFF_FF80);
    apply(mk(1, 1, 8, 1, 32'h101, 32'h80FF_7F01, 0, 2, 1, 0, 0));
    chk("lbu.a1", ifa.writeData, 32'h0000_00FF);
    apply(mk(1, 1, 8, 1, 32'h103, 32'h80FF_7F01, 0, 2, 0, 0, 0));
    chk("lb.a3", ifa.writeData, 32'h0000_0001);
    apply(mk(1, 1, 9, 1, 32'h202, 32'h8001_7FFE, 0, 1, 0, 0, 0));
    chk("lh.a2", ifa.writeData, 32'h0000_7FFE);
    apply(mk(1, 1, 9, 1, 32'h200, 32'h8001_7FFE, 0, 1, 0, 0, 0));
    chk("lh.a0", ifa.writeData, 32'hFFFF_8001);
    apply(mk(1, 1, 9, 1, 32'h201, 32'h8001_7FFE, 0, 1, 0, 0, 0));
    chk("lh.a1.fault", ifa.load_fault, 1);
    chk("lh.a1.regWrite", ifa.regWrite, 0);
    chk("lh.a1.valid", ifa.wb_valid, 1);
    apply(mk(1, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0));
    chk("r0.regWrite", ifa.regWrite, 0);
    apply(mk(1, 1, 31, 2, 0, 0, 32'h0040_0008, 0, 0, 0, 0));
    chk("jal.writeData", ifa.writeData, 32'h0040_0008);
    chk("jal.writeReg", ifa.writeReg, 31);

    apply(mk(1, 1, 5, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      apply(mk(1, 1, 5'(i + 10), 0, $urandom, 0, 0, 0, 0, 1, 0));
      chk("stall.writeData", ifa.writeData, 32'h0000_1234);
      chk("stall.writeReg", ifa.writeReg, 5);
    end
    apply(mk(1, 1, 7, 0, 32'h55, 0, 0, 0, 0, 1, 1));
    chk("flushstall.valid", ifa.wb_valid, 0);
    chk("flushstall.regWrite", ifa.regWrite, 0);

    do_reset();
    for (int i = 0; i < 16; i++) apply(mk(1, 1, 1, 0, 32'(i), 0, 0, 0, 0, 0, 0));
    chk("wrap.allones", ifb.retired, 4'hF);
    apply(idle);
    chk("wrap.zero", ifb.retired, 0);
    chk("wrap.retiredA", ifa.retired, 16);

    apply(mk(1, 1, 3, 0, 32'h77, 0, 0, 0, 0, 0, 0));
    #1;
    do_reset();

    for (int i = 0; i < 400; i++) begin
      stim_t x;
      x.v   = ($urandom_range(0, 9) < 8);
      x.rw  = ($urandom_range(0, 9) < 8);
      x.wr  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      x.m2r = 2'($urandom_range(0, 3));
      x.alu = $urandom;
      x.rd  = $urandom;
      x.pc  = $urandom;
      x.ls  = 2'($urandom_range(0, 3));
      x.lu  = 1'($urandom_range(0, 1));
      x.st  = ($urandom_range(0, 99) < 15);
      x.fl  = ($urandom_range(0, 99) < 8);
      apply(x);
      if (i == 200) begin
        #1;
        do_reset();
      end
    end
    apply(idle);
    apply(idle);
    @(negedge clock);
    #1;
    chk("drainA", qa.size(), 0);
    chk("drainB", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback-select logic for the 32-bit MIPS pipeline.
- Captures the memory-stage result on the rising edge and performs load byte/half extraction and sign extension.
- Drives the register file's regWrite, writeReg and writeData, held stable across the register file's negedge write.
- Also counts retired instructions and flags misaligned loads.

Parameters:
- BIG_ENDIAN, 1, byte-lane order for sub-word loads (1 = MIPS big-endian, 0 = little-endian)
- CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clock  input  1  system clock; stage registers update on the posedge
- reset_n  input  1  asynchronous active-low reset
- mem_valid  input  1  MEM stage holds a real instruction
- mem_regWrite  input  1  instruction writes a GPR
- mem_writeReg  input  5  destination register number
- mem_memToReg  input  2  source select: 00 ALU, 01 load, 10 link (PC+4), 11 reserved
- mem_aluResult  input  32  ALU result; also the load address
- mem_readData  input  32  raw word read from data memory
- mem_pcPlus4  input  32  link value
- mem_loadSize  input  2  00 word, 01 half, 10 byte, 11 reserved
- mem_loadUnsigned  input  1  1 = zero-extend, 0 = sign-extend
- stall  input  1  hold the WB contents
- flush  input  1  invalidate the WB contents
- regWrite  output  1  register file write enable
- writeReg  output  5  register file write address
- writeData  output  32  register file write data
- wb_valid  output  1  WB stage holds a valid instruction
- load_fault  output  1  misaligned load in WB; its write is suppressed
- retired  output  CNT_WIDTH  count of retired instructions

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset (asynchronous assert, synchronous release): wb_valid=0, regWrite=0, writeReg=0, writeData=0, load_fault=0, retired=0.
- Priority at each posedge: flush > stall > capture.
  - flush: wb_valid<=0, regWrite<=0, load_fault<=0; writeReg and writeData may hold.
  - stall (without flush): all stage registers hold.
  - Otherwise: capture the computed next values from the MEM inputs.
- Latency: MEM inputs appear on the outputs one posedge later. The register file writes at the following negedge. All outputs are registered, with no combinational path from input to output.
- Writeback data is computed combinationally before the register:
  - memToReg=00: aluResult.
  - memToReg=10: pcPlus4.
  - memToReg=11: 0, with the write suppressed.
  - memToReg=01: word, half or byte per loadSize, using address a = aluResult[1:0].
- Word load: readData. Misaligned if a != 00.
- Half load: misaligned if a[0]=1. BIG_ENDIAN=1: a[1]=0 takes readData[31:16], a[1]=1 takes readData[15:0]. BIG_ENDIAN=0 reverses this.
- Byte load: BIG_ENDIAN=1 selects lane 3-a, where lane k = readData[8k+7:8k]. BIG_ENDIAN=0 selects lane a.
- Extension: zero-extend if loadUnsigned=1, otherwise sign-extend from bit 15 (half) or bit 7 (byte).
- loadSize=11 on a load is treated as misaligned.
- Next regWrite = mem_valid & mem_regWrite & (mem_writeReg != 0) & !misaligned & (memToReg != 11).
  - The destination-0 write is suppressed here as well as in the register file.
- Next load_fault = mem_valid & (memToReg==01) & misaligned.
- Next wb_valid = mem_valid. A faulted load is still valid and still retires.
- retired increments by 1 on each posedge where wb_valid=1 and stall=0. The increment uses the pre-edge wb_valid. It wraps from all-ones to 0.
  - Flush and increment in the same cycle: the increment for the instruction leaving WB still counts.
- Reset asserted mid-operation clears all state immediately, with no write pulse.
- Simultaneous stall and mem_valid: the MEM input is ignored. Upstream holds it.

Test Plan:
- Reset, then ALU op (memToReg=00, writeReg=5, aluResult=0x0000_1234, regWrite=1) -> next posedge: regWrite=1, writeReg=5, writeData=0x0000_1234, wb_valid=1; following edge: retired=1.
- Byte load, readData=0x80FF_7F01, BIG_ENDIAN=1: a=0 signed -> 0xFFFF_FF80; a=1 unsigned -> 0x0000_00FF; a=3 signed -> 0x0000_0001.
- Half load, readData=0x8001_7FFE: a=2 signed -> 0x0000_7FFE; a=0 signed -> 0xFFFF_8001; a=1 -> load_fault=1, regWrite=0, wb_valid=1.
- writeReg=0 with regWrite=1 and ALU data 0xDEAD_BEEF -> regWrite=0. jal (memToReg=10, writeReg=31, pcPlus4=0x0040_0008) -> writeData=0x0040_0008.
- Stall held 3 cycles with changing MEM inputs -> outputs constant and retired unchanged; flush plus stall together -> wb_valid=0 next edge.
- Preload retired to all-ones (CNT_WIDTH=4 variant) and retire one instruction -> 0. Assert reset_n=0 between edges -> all outputs 0 immediately.
